// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the PC, issues one outstanding word request
// to instruction memory and hands {instr, pc, pc+4} to decode through a
// valid/ready output register backed by a single-entry skid buffer.
// Branch/jump redirects flush the output path and squash in-flight fetches.
// Optional: define FETCH_PERF_CNT_EN to add transfer/stall counters.
module fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_pc_plus4_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched_o,
    output logic [31:0]     perf_stall_o
`endif
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic            req_en_q;
    logic            drop_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic            out_valid_q;
    logic [XLEN-1:0] out_instr_q, out_pc_q, out_pc4_q;
    logic [XLEN-1:0] skid_instr_q, skid_pc_q, skid_pc4_q;
    logic            granted;
    logic            resp;
    logic            out_free;

    assign pc_next  = pc_q + PC_STEP;
    assign granted  = imem_req_o & imem_gnt_i;
    assign resp     = (state_q == S_WAIT) & imem_rvalid_i;
    assign out_free = !out_valid_q | id_ready_i;

    assign id_valid_o    = out_valid_q;
    assign id_instr_o    = out_instr_q;
    assign id_pc_o       = out_pc_q;
    assign id_pc_plus4_o = out_pc4_q;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_REQ;
        else       state_q <= state_d;
    end

    // Next-state logic; a redirect only changes the state where it must abandon HOLD or a returning response
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ:  if (granted) state_d = S_WAIT;
            S_WAIT: if (imem_rvalid_i) begin
                        if (drop_q || out_free) state_d = S_REQ;
                        else                    state_d = S_HOLD;
                    end
            S_HOLD: if (id_ready_i) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
        if (redirect_i && (state_q == S_HOLD || resp)) state_d = S_REQ;
    end

    // Memory request outputs; suppressed until the first edge after reset release
    always_comb begin
        imem_req_o  = req_en_q && (state_q == S_REQ);
        imem_addr_o = pc_q;
    end

    // PC, squash flag, output register and skid buffer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_en_q     <= 1'b0;
            drop_q       <= 1'b0;
            pc_q         <= RESET_PC;
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_pc_q     <= '0;
            out_pc4_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_pc4_q   <= '0;
        end else begin
            req_en_q <= 1'b1;
            if (redirect_i) begin
                pc_q        <= {redirect_pc_i[XLEN-1:2], 2'b00};
                out_valid_q <= 1'b0;
                drop_q      <= granted || ((state_q == S_WAIT) && !imem_rvalid_i);
            end else begin
                if (id_ready_i) out_valid_q <= 1'b0;
                if (resp) begin
                    if (drop_q) begin
                        drop_q <= 1'b0;
                    end else if (out_free) begin
                        out_valid_q <= 1'b1;
                        out_instr_q <= imem_rdata_i;
                        out_pc_q    <= pc_q;
                        out_pc4_q   <= pc_next;
                        pc_q        <= pc_next;
                    end else begin
                        skid_instr_q <= imem_rdata_i;
                        skid_pc_q    <= pc_q;
                        skid_pc4_q   <= pc_next;
                        pc_q         <= pc_next;
                    end
                end else if ((state_q == S_HOLD) && id_ready_i) begin
                    out_valid_q <= 1'b1;
                    out_instr_q <= skid_instr_q;
                    out_pc_q    <= skid_pc_q;
                    out_pc4_q   <= skid_pc4_q;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Transfer and stall counters, free-running modulo 2^32
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_fetched_o <= '0;
            perf_stall_o   <= '0;
        end else begin
            if (out_valid_q && id_ready_i)  perf_fetched_o <= perf_fetched_o + 32'd1;
            if (out_valid_q && !id_ready_i) perf_stall_o   <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule
